// File: rtl/router_pkg.sv
// router_pkg: shared router defaults, input-port indices and arbiter one-hot states
package router_pkg;
    localparam int ROUTER_DATA_WIDTH = 32;
    localparam int ROUTER_DEPTH      = 4;
    typedef enum logic [2:0] {PORT_N, PORT_E, PORT_W, PORT_S, PORT_L} port_e;
    localparam logic [5:0] ARB_IDLE = 6'b000001;
    localparam logic [5:0] ARB_L    = 6'b000010;
    localparam logic [5:0] ARB_N    = 6'b000100;
    localparam logic [5:0] ARB_E    = 6'b001000;
    localparam logic [5:0] ARB_W    = 6'b010000;
    localparam logic [5:0] ARB_S    = 6'b100000;
endpackage

// File: rtl/router_input_fifo.sv
// router_input_fifo: router input-port flit FIFO with DRTS/CTS upstream handshake
//   clk, rst                  clock, synchronous active-high reset
//   RX, DRTS                  upstream flit and request-to-send level
//   CTS                       registered one-cycle accept pulse to upstream
//   read_en_N/E/W/S/L         pop requests from the granting output arbiters
//   Data_out, empty_out       zero-latency head flit, FIFO empty
//   full_out                  FIFO holds DEPTH flits
//   err_multi_read            sticky: more than one read_en high in one cycle
module router_input_fifo
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
    parameter int DEPTH      = ROUTER_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  DRTS,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic                  CTS,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty_out,
    output logic                  full_out,
    output logic                  err_multi_read
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic [2:0] rd_cnt;
    logic wr, rd;
    assign rd_cnt = 3'(read_en_N) + 3'(read_en_E) + 3'(read_en_W) + 3'(read_en_S) + 3'(read_en_L);
    // CTS=0 in the condition enforces the one-flit-per-two-cycles handshake
    assign wr = DRTS && !CTS && !full_out;
    assign rd = (rd_cnt != 3'd0) && !empty_out;
    assign empty_out = count == '0;
    assign full_out = count == (AW+1)'(DEPTH);
    assign Data_out = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (wr && !rst) mem[wr_ptr] <= RX;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            CTS <= 1'b0;
            err_multi_read <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
            CTS <= wr;
            if (rd_cnt > 3'd1) err_multi_read <= 1'b1;
        end
    end
endmodule

// File: tb/tb_router_input_fifo.sv
// tb_router_input_fifo: scoreboard bench for router_input_fifo
module tb_router_input_fifo;
    import router_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] RX = '0;
    logic DRTS = 1'b0;
    logic read_en_N = 0, read_en_E = 0, read_en_W = 0, read_en_S = 0, read_en_L = 0;
    logic CTS, empty_out, full_out, err_multi_read;
    logic [31:0] Data_out;
    logic [31:0] q[$];
    int total = 0;
    int passed = 0;

    router_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .RX(RX), .DRTS(DRTS),
        .read_en_N(read_en_N), .read_en_E(read_en_E), .read_en_W(read_en_W),
        .read_en_S(read_en_S), .read_en_L(read_en_L),
        .CTS(CTS), .Data_out(Data_out), .empty_out(empty_out),
        .full_out(full_out), .err_multi_read(err_multi_read)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_rd(input port_e p, input logic v);
        case (p)
            PORT_N: read_en_N = v;
            PORT_E: read_en_E = v;
            PORT_W: read_en_W = v;
            PORT_S: read_en_S = v;
            default: read_en_L = v;
        endcase
    endtask

    // drive a flit and wait (bounded) for its CTS pulse; DRTS stays high on return
    task automatic send(input logic [31:0] v, output logic ok);
        DRTS = 1'b1;
        RX = v;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = CTS;
        end
        if (ok) q.push_back(v);
    endtask

    // one-cycle pop on port p, head compared against the scoreboard
    task automatic pop(input port_e p, input string name);
        logic [31:0] exp;
        exp = q.size() != 0 ? q.pop_front() : 32'hDEAD_BEEF;
        set_rd(p, 1'b1);
        total++;
        if (Data_out !== exp) $display("FAIL %s: Data_out=%h expected %h", name, Data_out, exp);
        else passed++;
        @(negedge clk);
        set_rd(p, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        DRTS = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (CTS !== 1'b0) $display("FAIL reset_cts: got %b want 0", CTS); else passed++;
        total++; if (empty_out !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty_out); else passed++;
        total++; if (full_out !== 1'b0) $display("FAIL reset_full: got %b want 0", full_out); else passed++;
        total++; if (err_multi_read !== 1'b0) $display("FAIL reset_err: got %b want 0", err_multi_read); else passed++;
    endtask

    task automatic test_single;
        logic ok;
        send(32'hA5A5_0001, ok);
        DRTS = 1'b0;
        total++; if (!ok) $display("FAIL single_cts: CTS=0 want pulse"); else passed++;
        total++; if (empty_out !== 1'b0) $display("FAIL single_empty: got %b want 0", empty_out); else passed++;
        @(negedge clk);
        total++; if (CTS !== 1'b0) $display("FAIL single_cts_width: got %b want 0", CTS); else passed++;
        pop(PORT_E, "single_data");
        total++; if (empty_out !== 1'b1) $display("FAIL single_drain: empty=%b want 1", empty_out); else passed++;
    endtask

    task automatic test_fill;
        logic ok;
        int pulses;
        for (int i = 1; i <= 4; i++) begin
            send(32'(i), ok);
            total++; if (!ok) $display("FAIL fill_accept_%0d: no CTS", i); else passed++;
        end
        RX = 32'd5;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (CTS) pulses++;
        end
        total++; if (full_out !== 1'b1) $display("FAIL fill_full: got %b want 1", full_out); else passed++;
        total++; if (pulses != 0) $display("FAIL fill_blocked: %0d CTS pulses want 0", pulses); else passed++;
        pop(PORT_N, "fill_head");
        send(32'd5, ok);
        DRTS = 1'b0;
        total++; if (!ok) $display("FAIL fill_fifth: no CTS after pop"); else passed++;
        @(negedge clk);
        for (int i = 0; i < 4; i++) pop(PORT_W, "fill_drain");
        total++; if (empty_out !== 1'b1) $display("FAIL fill_empty: got %b want 1", empty_out); else passed++;
    endtask

    task automatic test_wrap;
        logic ok;
        for (int i = 1; i <= 6; i++) begin
            send(32'(i), ok);
            total++; if (!ok) $display("FAIL wrap_accept_%0d: no CTS", i); else passed++;
            pop(PORT_L, "wrap_order");
        end
        DRTS = 1'b0;
        @(negedge clk);
        total++; if (empty_out !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty_out); else passed++;
    endtask

    task automatic test_simultaneous;
        logic ok;
        send(32'h10, ok);
        DRTS = 1'b0;
        @(negedge clk);
        DRTS = 1'b1;
        RX = 32'h20;
        q.push_back(32'h20);
        pop(PORT_S, "simul_old_head");
        DRTS = 1'b0;
        total++; if (CTS !== 1'b1) $display("FAIL simul_cts: got %b want 1", CTS); else passed++;
        total++; if (empty_out !== 1'b0) $display("FAIL simul_count: empty=%b want 0", empty_out); else passed++;
        total++; if (Data_out !== q[0]) $display("FAIL simul_new_head: got %h want %h", Data_out, q[0]); else passed++;
        pop(PORT_S, "simul_drain");
        total++; if (empty_out !== 1'b1) $display("FAIL simul_empty: got %b want 1", empty_out); else passed++;
    endtask

    task automatic test_error_empty;
        logic ok;
        send(32'hB1, ok);
        send(32'hB2, ok);
        DRTS = 1'b0;
        @(negedge clk);
        read_en_W = 1'b1;
        pop(PORT_N, "multi_head");
        read_en_W = 1'b0;
        total++; if (err_multi_read !== 1'b1) $display("FAIL multi_err: got %b want 1", err_multi_read); else passed++;
        total++; if (Data_out !== q[0]) $display("FAIL multi_one_pop: got %h want %h", Data_out, q[0]); else passed++;
        repeat (3) @(negedge clk);
        total++; if (err_multi_read !== 1'b1) $display("FAIL multi_sticky: got %b want 1", err_multi_read); else passed++;
        pop(PORT_E, "multi_drain");
        total++; if (empty_out !== 1'b1) $display("FAIL multi_empty: got %b want 1", empty_out); else passed++;
        read_en_E = 1'b1;
        @(negedge clk);
        read_en_E = 1'b0;
        total++; if (empty_out !== 1'b1 || full_out !== 1'b0) $display("FAIL empty_read: empty=%b full=%b want 1 0", empty_out, full_out); else passed++;
        send(32'hC3, ok);
        DRTS = 1'b0;
        @(negedge clk);
        total++; if (Data_out !== 32'hC3) $display("FAIL empty_read_ptr: head %h want c3", Data_out); else passed++;
    endtask

    task automatic test_mid_reset;
        logic ok;
        send(32'hE1, ok);
        RX = 32'hE2;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        DRTS = 1'b0;
        q.delete();
        total++; if (empty_out !== 1'b1) $display("FAIL rst_mid_empty: got %b want 1", empty_out); else passed++;
        total++; if (CTS !== 1'b0) $display("FAIL rst_mid_cts: got %b want 0", CTS); else passed++;
        total++; if (err_multi_read !== 1'b0) $display("FAIL rst_mid_err: got %b want 0", err_multi_read); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_error_empty();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
